register_file_sv: RTL and testbench
===================================

# register_file_sv

Dual-bank architectural register file at the receiving end of the writeback interface. Accepts scalar (N-bit) and vector (V-bit) results with a shared destination address from the writeback stage and serves Decode through two combinational read ports per bank, with same-cycle write-to-read bypass. A per-bank scoreboard tracks destinations of in-flight instructions and raises a Decode stall on read-after-write hazards.

## Interface
- N, 32, scalar register width
- V, 256, vector register width
- R, 5, register address width; each bank holds 2^R registers
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- RegWriteW  in  1  scalar write enable from writeback
- RegWriteVW  in  1  vector write enable from writeback
- WA3W  in  R  destination address shared by both banks
- ResultW  in  N  scalar write data
- ResultVW  in  V  vector write data
- RA1D, RA2D  in  R each  scalar read addresses
- RVA1D, RVA2D  in  R each  vector read addresses
- IssueD  in  1  instruction leaves Decode this cycle and claims its destination
- IssueVecD  in  1  claimed destination is in the vector bank (0 = scalar)
- WA3D  in  R  destination claimed on issue
- RD1D, RD2D  out  N each  scalar read data
- RDV1D, RDV2D  out  V each  vector read data
- StallD  out  1  a source read this cycle has a pending write
- BusyS, BusyV  out  2^R each  scoreboard state, for verification and hazard unit

## Operation
- Scalar bank: register 0 reads 0; writes to it ignored; never marked busy. Vector register 0 is an ordinary register.
- Write: on rising edge with rst=1, RegWriteW writes ResultW to scalar[WA3W]; RegWriteVW writes ResultVW to vector[WA3W]. Both may assert in the same cycle; each bank writes independently.
- Read: combinational. If the port address equals WA3W and the matching bank's write enable is high (scalar: address ≠ 0), output the incoming write data (bypass); else the stored value.
- Scoreboard per bank, one bit per register:
  - Set: IssueD=1 sets BusyV[WA3D] if IssueVecD=1, else BusyS[WA3D] (unless WA3D=0).
  - Clear: RegWriteW clears BusyS[WA3W]; RegWriteVW clears BusyV[WA3W].
  - Set and clear of the same bit in one cycle: set wins (newer instruction owns it).
- StallD = 1 when any of RA1D, RA2D (scalar, address ≠ 0) or RVA1D, RVA2D has its busy bit set and is not being cleared by a write this same cycle. Decode applies this to source ports it uses; StallD does not block IssueD (Decode must not issue while stalled).

## Timing
- Reset: any rising edge with rst=0 clears all registers of both banks and all busy bits; writes and issue sets are suppressed. While rst=0, RD*/RDV* and StallD are forced 0. Reset applied mid-stream discards in-flight claims; first edge with rst=1 behaves normally.
- Read latency 0 cycles (combinational incl. bypass); write visible in stored array the cycle after the edge, and via bypass in the write cycle.
- Busy bit set at the edge where IssueD=1; visible on BusyS/BusyV and StallD the next cycle.
- Busy clear takes effect combinationally on StallD in the write cycle (matches bypass), in BusyS/BusyV after the edge.
- Address compare is exact over R bits; no wrap-around.

## Test plan
- Reset: write scalar[3]=0xDEADBEEF, assert rst=0 for one edge -> RD1D(RA1D=3)=0, BusyS=0, BusyV=0; all outputs 0 while rst=0.
- Scalar write/read and r0: write scalar[5]=0x12345678, scalar[0]=0xFFFFFFFF -> next cycle RD1D(5)=0x12345678, RD2D(0)=0; BusyS[0] never set on IssueD with WA3D=0.
- Bypass: RegWriteVW=1, WA3W=7, ResultVW=all 0xA5 bytes, RVA1D=7 same cycle -> RDV1D=0xA5…A5 before the edge; stored value confirmed next cycle with writes off.
- Dual-bank write: RegWriteW=RegWriteVW=1, WA3W=9 -> scalar[9] and vector[9] both updated; neither bank disturbed elsewhere.
- Scoreboard hazard: IssueD=1, IssueVecD=0, WA3D=4; next cycle RA1D=4 -> StallD=1, BusyS[4]=1; cycle where RegWriteW=1, WA3W=4 -> StallD=0 and RD1D=ResultW; after edge BusyS[4]=0.
- Set/clear collision: IssueD=1 with WA3D=6 vector while RegWriteVW=1, WA3W=6 -> after edge BusyV[6]=1; RVA2D=6 next cycle -> StallD=1.

Source files
------------

// File: rtl/register_file_sv.sv
// Dual-bank (scalar/vector) register file with write-to-read bypass and a per-bank
// busy scoreboard that flags read-after-write hazards to Decode.
module register_file_sv #(
    parameter int N = 32,
    parameter int V = 256,
    parameter int R = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                RegWriteW,
    input  logic                RegWriteVW,
    input  logic [R-1:0]        WA3W,
    input  logic [N-1:0]        ResultW,
    input  logic [V-1:0]        ResultVW,
    input  logic [R-1:0]        RA1D,
    input  logic [R-1:0]        RA2D,
    input  logic [R-1:0]        RVA1D,
    input  logic [R-1:0]        RVA2D,
    input  logic                IssueD,
    input  logic                IssueVecD,
    input  logic [R-1:0]        WA3D,
    output logic [N-1:0]        RD1D,
    output logic [N-1:0]        RD2D,
    output logic [V-1:0]        RDV1D,
    output logic [V-1:0]        RDV2D,
    output logic                StallD,
    output logic [(1<<R)-1:0]   BusyS,
    output logic [(1<<R)-1:0]   BusyV
);
    localparam int NR = 1 << R;

    logic [N-1:0]  sreg_q [NR];
    logic [V-1:0]  vreg_q [NR];
    logic [NR-1:0] busy_s_q, busy_s_d;
    logic [NR-1:0] busy_v_q, busy_v_d;

    logic s_wr, v_wr;
    assign s_wr = RegWriteW && (WA3W != '0);
    assign v_wr = RegWriteVW;

    // Clear from writeback first, then the newer issue claim overrides it.
    always_comb begin
        busy_s_d = busy_s_q;
        busy_v_d = busy_v_q;
        if (RegWriteW)
            busy_s_d[WA3W] = 1'b0;
        if (RegWriteVW)
            busy_v_d[WA3W] = 1'b0;
        if (IssueD && IssueVecD)
            busy_v_d[WA3D] = 1'b1;
        if (IssueD && !IssueVecD && (WA3D != '0))
            busy_s_d[WA3D] = 1'b1;
        busy_s_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin
                sreg_q[i] <= '0;
                vreg_q[i] <= '0;
            end
            busy_s_q <= '0;
            busy_v_q <= '0;
        end else begin
            if (s_wr)
                sreg_q[WA3W] <= ResultW;
            if (v_wr)
                vreg_q[WA3W] <= ResultVW;
            busy_s_q <= busy_s_d;
            busy_v_q <= busy_v_d;
        end
    end

    // Scalar entry 0 is never written, so reading it returns the reset value 0.
    always_comb begin
        RD1D  = '0;
        RD2D  = '0;
        RDV1D = '0;
        RDV2D = '0;
        if (rst) begin
            RD1D  = (s_wr && (RA1D == WA3W))  ? ResultW  : sreg_q[RA1D];
            RD2D  = (s_wr && (RA2D == WA3W))  ? ResultW  : sreg_q[RA2D];
            RDV1D = (v_wr && (RVA1D == WA3W)) ? ResultVW : vreg_q[RVA1D];
            RDV2D = (v_wr && (RVA2D == WA3W)) ? ResultVW : vreg_q[RVA2D];
        end
    end

    logic pend_s1, pend_s2, pend_v1, pend_v2;
    always_comb begin
        pend_s1 = (RA1D != '0) && busy_s_q[RA1D] && !(RegWriteW && (WA3W == RA1D));
        pend_s2 = (RA2D != '0) && busy_s_q[RA2D] && !(RegWriteW && (WA3W == RA2D));
        pend_v1 = busy_v_q[RVA1D] && !(RegWriteVW && (WA3W == RVA1D));
        pend_v2 = busy_v_q[RVA2D] && !(RegWriteVW && (WA3W == RVA2D));
        StallD  = rst && (pend_s1 || pend_s2 || pend_v1 || pend_v2);
    end

    assign BusyS = busy_s_q;
    assign BusyV = busy_v_q;

endmodule

// File: tb/tb_register_file_sv.sv
// Bench for register_file_sv: reference model of both banks and the scoreboard,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_register_file_sv;
  localparam int N = 32;
  localparam int V = 256;
  localparam int R = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          RegWriteW, RegWriteVW;
  logic [R-1:0]  WA3W;
  logic [N-1:0]  ResultW;
  logic [V-1:0]  ResultVW;
  logic [R-1:0]  RA1D, RA2D, RVA1D, RVA2D;
  logic          IssueD, IssueVecD;
  logic [R-1:0]  WA3D;
  logic [N-1:0]  RD1D, RD2D;
  logic [V-1:0]  RDV1D, RDV2D;
  logic          StallD;
  logic [31:0]   BusyS, BusyV;

  register_file_sv #(.N(N), .V(V), .R(R)) dut (
    .clk(clk), .rst(rst),
    .RegWriteW(RegWriteW), .RegWriteVW(RegWriteVW), .WA3W(WA3W),
    .ResultW(ResultW), .ResultVW(ResultVW),
    .RA1D(RA1D), .RA2D(RA2D), .RVA1D(RVA1D), .RVA2D(RVA2D),
    .IssueD(IssueD), .IssueVecD(IssueVecD), .WA3D(WA3D),
    .RD1D(RD1D), .RD2D(RD2D), .RDV1D(RDV1D), .RDV2D(RDV2D),
    .StallD(StallD), .BusyS(BusyS), .BusyV(BusyV)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
  endtask

  // reference model
  logic [N-1:0] m_s [32];
  logic [V-1:0] m_v [32];
  logic [31:0]  m_bs = '0;
  logic [31:0]  m_bv = '0;

  initial for (int i = 0; i < 32; i++) begin m_s[i] = '0; m_v[i] = '0; end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin m_s[i] <= '0; m_v[i] <= '0; end
      m_bs <= '0;
      m_bv <= '0;
    end else begin
      if (RegWriteW && WA3W != 0) m_s[WA3W] <= ResultW;
      if (RegWriteVW) m_v[WA3W] <= ResultVW;
      m_bs <= ((m_bs & ~(RegWriteW ? (32'd1 << WA3W) : 32'd0))
               | ((IssueD && !IssueVecD && WA3D != 0) ? (32'd1 << WA3D) : 32'd0));
      m_bv <= ((m_bv & ~(RegWriteVW ? (32'd1 << WA3W) : 32'd0))
               | ((IssueD && IssueVecD) ? (32'd1 << WA3D) : 32'd0));
    end
  end

  function automatic logic [N-1:0] exp_s(input logic [R-1:0] a);
    if (!rst) return '0;
    if (RegWriteW && a == WA3W && a != 0) return ResultW;
    return m_s[a];
  endfunction

  function automatic logic [V-1:0] exp_v(input logic [R-1:0] a);
    if (!rst) return '0;
    if (RegWriteVW && a == WA3W) return ResultVW;
    return m_v[a];
  endfunction

  function automatic logic pend_s(input logic [R-1:0] a);
    return a != 0 && m_bs[a] && !(RegWriteW && WA3W == a);
  endfunction

  function automatic logic pend_v(input logic [R-1:0] a);
    return m_bv[a] && !(RegWriteVW && WA3W == a);
  endfunction

  // scoreboard compare, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("RD1D", V'(RD1D), V'(exp_s(RA1D)));
      chk("RD2D", V'(RD2D), V'(exp_s(RA2D)));
      chk("RDV1D", RDV1D, exp_v(RVA1D));
      chk("RDV2D", RDV2D, exp_v(RVA2D));
      chk("StallD", V'(StallD),
          V'(rst && (pend_s(RA1D) || pend_s(RA2D) || pend_v(RVA1D) || pend_v(RVA2D))));
      chk("BusyS", V'(BusyS), V'(m_bs));
      chk("BusyV", V'(BusyV), V'(m_bv));
    end
  end

  // driver tasks
  task automatic idle();
    RegWriteW = 0; RegWriteVW = 0; IssueD = 0; IssueVecD = 0;
    WA3W = 0; WA3D = 0; ResultW = '0; ResultVW = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  logic [V-1:0] a5_pat;
  logic [V-1:0] p9_pat;

  initial begin
    a5_pat = {32{8'hA5}};
    p9_pat = {8{32'h9000_0009}};
    rst = 0; idle();
    RA1D = 0; RA2D = 0; RVA1D = 0; RVA2D = 0;
    step();
    chk_en = 1;
    step();
    rst = 1;

    // reset clears stored data
    RegWriteW = 1; WA3W = 3; ResultW = 32'hDEADBEEF;
    step();
    idle(); rst = 0; RA1D = 3;
    mid();
    chk("lit_rd_in_reset", V'(RD1D), '0);
    step();
    rst = 1;
    mid();
    chk("lit_rd3_after_reset", V'(RD1D), '0);
    chk("lit_busys_after_reset", V'(BusyS), '0);
    chk("lit_busyv_after_reset", V'(BusyV), '0);
    step();

    // scalar write/read and r0
    RegWriteW = 1; WA3W = 5; ResultW = 32'h12345678;
    step();
    WA3W = 0; ResultW = 32'hFFFFFFFF;
    step();
    idle(); RA1D = 5; RA2D = 0; IssueD = 1; IssueVecD = 0; WA3D = 0;
    mid();
    chk("lit_rd5", V'(RD1D), V'(32'h12345678));
    chk("lit_rd_r0", V'(RD2D), '0);
    step();
    idle();
    mid();
    chk("lit_busys_r0", V'(BusyS), '0);
    step();

    // vector bypass then stored value
    RegWriteVW = 1; WA3W = 7; ResultVW = a5_pat; RVA1D = 7;
    mid();
    chk("lit_bypass_v7", RDV1D, a5_pat);
    step();
    idle();
    mid();
    chk("lit_stored_v7", RDV1D, a5_pat);
    step();

    // dual-bank write
    RegWriteW = 1; RegWriteVW = 1; WA3W = 9; ResultW = 32'hCAFEF00D; ResultVW = p9_pat;
    step();
    idle(); RA1D = 9; RA2D = 5; RVA1D = 7; RVA2D = 9;
    mid();
    chk("lit_dual_s9", V'(RD1D), V'(32'hCAFEF00D));
    chk("lit_dual_v9", RDV2D, p9_pat);
    chk("lit_dual_s5", V'(RD2D), V'(32'h12345678));
    chk("lit_dual_v7", RDV1D, a5_pat);
    step();

    // scalar hazard
    IssueD = 1; IssueVecD = 0; WA3D = 4;
    step();
    idle(); RA1D = 4;
    mid();
    chk("lit_stall_s4", V'(StallD), V'(1'b1));
    chk("lit_busys4", V'(BusyS[4]), V'(1'b1));
    step();
    RegWriteW = 1; WA3W = 4; ResultW = 32'h0000_0044;
    mid();
    chk("lit_stall_clear", V'(StallD), '0);
    chk("lit_rd4_bypass", V'(RD1D), V'(32'h44));
    step();
    idle();
    mid();
    chk("lit_busys4_cleared", V'(BusyS[4]), '0);
    step();

    // set/clear collision, set wins
    IssueD = 1; IssueVecD = 1; WA3D = 6;
    RegWriteVW = 1; WA3W = 6; ResultVW = {V{1'b1}};
    step();
    idle(); RVA2D = 6;
    mid();
    chk("lit_busyv6", V'(BusyV[6]), V'(1'b1));
    chk("lit_stall_v6", V'(StallD), V'(1'b1));
    step();

    // mid-stream reset drops claims
    IssueD = 1; IssueVecD = 0; WA3D = 10;
    step();
    idle(); rst = 0;
    mid();
    chk("lit_stall_in_reset", V'(StallD), '0);
    chk("lit_rdv_in_reset", RDV2D, '0);
    step();
    rst = 1;
    mid();
    chk("lit_busys_midreset", V'(BusyS), '0);
    chk("lit_busyv_midreset", V'(BusyV), '0);
    step();

    // mixed traffic against the model
    for (int i = 0; i < 60; i++) begin
      rst = (i == 30) ? 1'b0 : 1'b1;
      RegWriteW = 1'($urandom_range(0, 1));
      RegWriteVW = 1'($urandom_range(0, 1));
      WA3W = R'($urandom_range(0, 7));
      ResultW = $urandom();
      ResultVW = {8{$urandom()}};
      IssueD = 1'($urandom_range(0, 1));
      IssueVecD = 1'($urandom_range(0, 1));
      WA3D = R'($urandom_range(0, 7));
      RA1D = R'($urandom_range(0, 7));
      RA2D = R'($urandom_range(0, 7));
      RVA1D = R'($urandom_range(0, 7));
      RVA2D = R'($urandom_range(0, 7));
      step();
    end
    idle(); rst = 1;
    step();
    mid();
    chk_en = 0;

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
